// File: rtl/rle_decomp_ctrl_if.sv
// Control and RAM bus bundle for the RLE decompression sequencer.
interface rle_decomp_ctrl_if #(
    parameter int OUT_W = 16,
    parameter int RD_AW = 11,
    parameter int WR_AW = 10
);
    logic             start;
    logic [RD_AW:0]   num_words;
    logic             rd_en;
    logic [RD_AW-1:0] rd_addr;
    logic [15:0]      rd_data;
    logic             wr_en;
    logic [WR_AW-1:0] wr_addr;
    logic [OUT_W-1:0] wr_data;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        input  start, num_words, rd_data,
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output busy, done, err
    );

    modport slave (
        output start, num_words, rd_data,
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  busy, done, err
    );
endinterface

// File: rtl/rle_decomp_ctrl.sv
// Run-length image decompressor: RLE words in, MSB-first packed pixels out.
// Define RLE_FILL_EN to zero-fill short images up to IMG_BITS.
module rle_decomp_ctrl #(
    parameter int IMG_BITS = 16384,
    parameter int OUT_W    = 16,
    parameter int RD_AW    = 11,
    parameter int WR_AW    = 10
) (
    input logic               clk,
    input logic               rst,
    rle_decomp_ctrl_if.master bus
);
    localparam int PW = $clog2(IMG_BITS) + 1;
    localparam int FW = $clog2(OUT_W) + 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        EXPAND,
`ifdef RLE_FILL_EN
        FINISH,
        FILL
`else
        FINISH
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [RD_AW:0]   nwords_q, nwords_d;
    logic [RD_AW:0]   widx_q, widx_d;
    logic             run_bit_q, run_bit_d;
    logic [14:0]      run_len_q, run_len_d;
    logic [PW-1:0]    pix_q, pix_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [OUT_W-1:0] pack_q, pack_d;
    logic [WR_AW-1:0] waddr_q, waddr_d;
    logic             err_flag_q, err_flag_d;
    logic             wr_en_q, wr_en_d;
    logic [WR_AW-1:0] wr_addr_q, wr_addr_d;
    logic [OUT_W-1:0] wr_data_q, wr_data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [OUT_W-1:0] pack_n;
    int               f, n, fill_n, run_n, pix_n;

    assign bus.rd_en   = (state_q == FETCH);
    assign bus.rd_addr = widx_q[RD_AW-1:0];
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            nwords_q   <= '0;
            widx_q     <= '0;
            run_bit_q  <= 1'b0;
            run_len_q  <= '0;
            pix_q      <= '0;
            fill_q     <= '0;
            pack_q     <= '0;
            waddr_q    <= '0;
            err_flag_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            nwords_q   <= nwords_d;
            widx_q     <= widx_d;
            run_bit_q  <= run_bit_d;
            run_len_q  <= run_len_d;
            pix_q      <= pix_d;
            fill_q     <= fill_d;
            pack_q     <= pack_d;
            waddr_q    <= waddr_d;
            err_flag_q <= err_flag_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        nwords_d   = nwords_q;
        widx_d     = widx_q;
        run_bit_d  = run_bit_q;
        run_len_d  = run_len_q;
        pix_d      = pix_q;
        fill_d     = fill_q;
        pack_d     = pack_q;
        waddr_d    = waddr_q;
        err_flag_d = err_flag_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        pack_n     = pack_q;
        f          = 0;
        n          = 0;
        fill_n     = 0;
        run_n      = 0;
        pix_n      = 0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    nwords_d   = bus.num_words;
                    widx_d     = '0;
                    pix_d      = '0;
                    fill_d     = '0;
                    pack_d     = '0;
                    waddr_d    = '0;
                    err_flag_d = 1'b0;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                    if (bus.num_words == '0)
                        state_d = FINISH;
                    else
                        state_d = FETCH;
                end
            end

            FETCH: state_d = LOAD;

            LOAD: begin
                run_bit_d = bus.rd_data[15];
                run_len_d = bus.rd_data[14:0];
                widx_d    = widx_q + (RD_AW+1)'(1);
                if (bus.rd_data[14:0] != 15'd0)
                    state_d = EXPAND;
                else if (widx_d < nwords_q)
                    state_d = FETCH;
                else
                    state_d = FINISH;
            end

            EXPAND: begin
                // n = min(run left, room in pack word, pixels left in image)
                f = int'(fill_q);
                n = int'(run_len_q);
                if (OUT_W - f < n)
                    n = OUT_W - f;
                if (IMG_BITS - int'(pix_q) < n)
                    n = IMG_BITS - int'(pix_q);
                for (int i = 0; i < OUT_W; i++) begin
                    if (i >= f && i < f + n)
                        pack_n[OUT_W-1-i] = run_bit_q;
                end
                fill_n    = f + n;
                run_n     = int'(run_len_q) - n;
                pix_n     = int'(pix_q) + n;
                run_len_d = 15'(run_n);
                pix_d     = PW'(pix_n);
                if (fill_n == OUT_W) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = pack_n;
                    wr_addr_d = waddr_q;
                    waddr_d   = waddr_q + WR_AW'(1);
                    fill_d    = '0;
                    pack_d    = '0;
                end else begin
                    fill_d = FW'(fill_n);
                    pack_d = pack_n;
                end
                if (pix_n == IMG_BITS &&
                    (run_n != 0 || widx_q < nwords_q)) begin
                    err_flag_d = 1'b1;
                    state_d    = FINISH;
                end else if (run_n == 0) begin
                    if (widx_q < nwords_q)
                        state_d = FETCH;
                    else
                        state_d = FINISH;
                end
            end

            FINISH: begin
                if (pix_q == PW'(IMG_BITS)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    err_d   = err_flag_q;
                    state_d = IDLE;
                end
`ifdef RLE_FILL_EN
                else begin
                    state_d = FILL;
                end
`else
                else if (fill_q != '0) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = pack_q;
                    wr_addr_d = waddr_q;
                    waddr_d   = waddr_q + WR_AW'(1);
                    fill_d    = '0;
                    pack_d    = '0;
                end else begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
`endif
            end

`ifdef RLE_FILL_EN
            FILL: begin
                if (pix_q == PW'(IMG_BITS)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    err_d   = err_flag_q;
                    state_d = IDLE;
                end else begin
                    // unused pack bits are already zero
                    wr_en_d   = 1'b1;
                    wr_data_d = pack_q;
                    wr_addr_d = waddr_q;
                    waddr_d   = waddr_q + WR_AW'(1);
                    pix_d     = PW'(int'(pix_q) + OUT_W - int'(fill_q));
                    fill_d    = '0;
                    pack_d    = '0;
                end
            end
`endif

            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_rle_decomp_ctrl.sv
// Directed bench for rle_decomp_ctrl with IMG_BITS=64, OUT_W=16.
module tb_rle_decomp_ctrl;
    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:7];
    logic [9:0]  wlog_addr [0:255];
    logic [15:0] wlog_data [0:255];
    int          wcount = 0;
    int          dcount = 0;
    logic        derr;
    logic        dbusy;
    logic [15:0] exp_q [$];

    rle_decomp_ctrl_if #(.OUT_W(16), .RD_AW(11), .WR_AW(10)) bus ();

    rle_decomp_ctrl #(
        .IMG_BITS(64),
        .OUT_W   (16),
        .RD_AW   (11),
        .WR_AW   (10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.rd_en)
            bus.rd_data <= mem[bus.rd_addr[2:0]];
    end

    always @(negedge clk) begin
        if (bus.wr_en) begin
            wlog_addr[wcount[7:0]] <= bus.wr_addr;
            wlog_data[wcount[7:0]] <= bus.wr_data;
            wcount <= wcount + 1;
        end
        if (bus.done) begin
            dcount <= dcount + 1;
            derr   <= bus.err;
            dbusy  <= bus.busy;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_case(input string tag, input logic [11:0] nw,
                            input logic experr, input bit poke);
        int w0;
        int d0;
        w0 = wcount;
        d0 = dcount;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.num_words = nw;
        @(negedge clk);
        bus.start     = 1'b0;
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        if (poke) begin
            @(negedge clk);
            bus.start     = 1'b1;
            bus.num_words = 12'd1;
            @(negedge clk);
            bus.start     = 1'b0;
        end
        for (int k = 0; k < 300; k++) begin
            if (dcount != d0)
                break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check({tag, "_done"}, dcount - d0, 32'd1);
        check({tag, "_err"}, {31'd0, derr}, {31'd0, experr});
        check({tag, "_busy_at_done"}, {31'd0, dbusy}, 32'd0);
        check({tag, "_busy_after"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_nwrites"}, wcount - w0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i),
                  {16'd0, wlog_data[8'(w0 + i)]}, {16'd0, exp_q[i]});
            check($sformatf("%s_addr%0d", tag, i),
                  {22'd0, wlog_addr[8'(w0 + i)]}, i);
        end
    endtask

    initial begin
        int w0;
        int d0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.num_words = '0;
        for (int i = 0; i < 8; i++)
            mem[i] = 16'h0000;

        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_err", {31'd0, bus.err}, 32'd0);
        check("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
        check("rst_rd_en", {31'd0, bus.rd_en}, 32'd0);
        check("rst_wr_addr", {22'd0, bus.wr_addr}, 32'd0);
        check("rst_wr_data", {16'd0, bus.wr_data}, 32'd0);
        check("rst_rd_addr", {21'd0, bus.rd_addr}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // two runs, with an ignored start while busy
        mem[0] = 16'h8014;
        mem[1] = 16'h002C;
        exp_q  = '{16'hFFFF, 16'hF000, 16'h0000, 16'h0000};
        run_case("s1", 12'd2, 1'b0, 1'b1);

        mem[0] = 16'h8000;
        mem[1] = 16'h0040;
        exp_q  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        run_case("skip0", 12'd2, 1'b0, 1'b0);

        mem[0] = 16'h8046;
        exp_q  = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        run_case("overrun", 12'd1, 1'b1, 1'b0);

        mem[0] = 16'h8008;
`ifdef RLE_FILL_EN
        exp_q  = '{16'hFF00, 16'h0000, 16'h0000, 16'h0000};
        run_case("short", 12'd1, 1'b0, 1'b0);
`else
        exp_q  = '{16'hFF00};
        run_case("short", 12'd1, 1'b1, 1'b0);
`endif

`ifdef RLE_FILL_EN
        exp_q  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        run_case("nw0", 12'd0, 1'b0, 1'b0);
`else
        exp_q  = {};
        run_case("nw0", 12'd0, 1'b1, 1'b0);
`endif

        // reset while in EXPAND
        mem[0] = 16'h8014;
        mem[1] = 16'h002C;
        w0 = wcount;
        d0 = dcount;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.num_words = 12'd2;
        @(negedge clk);
        bus.start     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_rd_en", {31'd0, bus.rd_en}, 32'd0);
        check("abort_wr_en", {31'd0, bus.wr_en}, 32'd0);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_nwrites", wcount - w0, 32'd0);
        check("abort_ndone", dcount - d0, 32'd0);

        exp_q = '{16'hFFFF, 16'hF000, 16'h0000, 16'h0000};
        run_case("s1_again", 12'd2, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
